// File: rtl/attn_mem_pkg.sv
// -----------------------------------------------------------------------------
// attn_mem_pkg
// Shared constants and types for the attention memory bank.
//   DEF_*   : default geometry (word width, address width, depth, read channels)
//   state_e : bank controller state encoding (ST_INIT sweep, ST_READY service)
//   idx_w() : number of address bits actually needed to index DEPTH words
// -----------------------------------------------------------------------------
package attn_mem_pkg;

  localparam int DEF_DATA_W = 512;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DEPTH  = 4096;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Array index width; a single-word memory still needs one index bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/attn_mem_rd_port.sv
// -----------------------------------------------------------------------------
// attn_mem_rd_port
// One read channel of the attention memory bank: range check, read-during-write
// bypass selection and the registered data/valid pipeline.
// Optional feature macro: ATTN_MEM_OREG_EN adds a second output register stage
// (read latency 2 instead of 1).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   ready_i      : bank has finished its zero-fill sweep
//   rd_en_i      : read strobe for this channel
//   rd_addr_i    : read address
//   mem_word_i   : array word currently stored at rd_addr_i (pre-write value)
//   wr_en_i      : write strobe of the shared write port (already qualified)
//   wr_addr_i    : write address
//   wr_data_i    : write data
//   rd_data_o    : read data, held while rd_valid_o is low
//   rd_valid_o   : one-cycle pulse per accepted read
//   oor_o        : an accepted read this cycle is out of range
// -----------------------------------------------------------------------------
module attn_mem_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 16,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_word_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              oor_o
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  logic              acc_p0;
  logic              hit_p0;
  logic              byp_p0;
  logic [DATA_W-1:0] word_p0;

  logic              vld_p1_q;
  logic [DATA_W-1:0] data_p1_q;

  // Stage p0: request qualification and word selection
  always_comb begin
    acc_p0  = ready_i & rd_en_i;
    hit_p0  = in_range(rd_addr_i);
    // Equal addresses with an in-range read imply an in-range write.
    byp_p0  = (RDW_MODE == 1) && wr_en_i && (wr_addr_i == rd_addr_i);
    word_p0 = '0;
    if (hit_p0) begin
      word_p0 = byp_p0 ? wr_data_i : mem_word_i;
    end
    oor_o   = acc_p0 & ~hit_p0;
  end

  // Stage p1: first output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
    end else begin
      vld_p1_q <= acc_p0;
      if (acc_p0) begin
        data_p1_q <= word_p0;
      end
    end
  end

`ifdef ATTN_MEM_OREG_EN
  logic              vld_p2_q;
  logic [DATA_W-1:0] data_p2_q;

  // Stage p2: optional second output register, data and valid move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        data_p2_q <= data_p1_q;
      end
    end
  end

  assign rd_valid_o = vld_p2_q;
  assign rd_data_o  = data_p2_q;
`else
  assign rd_valid_o = vld_p1_q;
  assign rd_data_o  = data_p1_q;
`endif

endmodule

// File: rtl/attn_mem_bank.sv
// -----------------------------------------------------------------------------
// attn_mem_bank
// Single-write, multi-read memory bank for attention operands. After every
// reset release the array is zero-filled one word per cycle (INIT), then the
// bank services one write and NUM_RD reads per cycle (READY).
// Optional feature macro: ATTN_MEM_OREG_EN adds one output register stage per
// read channel (read latency 2 instead of 1).
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   wr_en      : write strobe
//   wr_addr    : write address
//   wr_data    : write data
//   rd_en      : per-channel read strobe
//   rd_addr    : packed read addresses, channel i at [i*ADDR_W +: ADDR_W]
//   rd_data    : packed read data, channel i at [i*DATA_W +: DATA_W]
//   rd_valid   : per-channel read-data valid pulse
//   init_done  : high while the bank is READY
//   addr_err   : sticky out-of-range access flag, cleared by reset only
// -----------------------------------------------------------------------------
module attn_mem_bank
  import attn_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int RDW_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     init_done,
  output logic                     addr_err
);

  localparam int              IDX_W   = idx_w(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ready;
  logic              wr_ok;
  logic              wr_qual;
  logic [NUM_RD-1:0] rd_oor;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word [NUM_RD];

  assign ready     = (state_q == ST_READY);
  assign wr_ok     = {1'b0, wr_addr} < DEPTH_C;
  assign wr_qual   = ready & wr_en;
  assign init_done = ready;
  assign addr_err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_A) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    err_d = err_q | (wr_qual & ~wr_ok) | (|rd_oor);
  end

  // The array itself is never reset; the INIT sweep owns the write port until
  // every word has been cleared.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[cnt_q[IDX_W-1:0]] <= '0;
    end else if (wr_en && wr_ok) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    // Out-of-range addresses may alias here; the port masks them to zero.
    assign rd_word[g] = mem[rd_addr[g*ADDR_W +: IDX_W]];

    attn_mem_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RDW_MODE (RDW_MODE)
    ) u_rd_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .ready_i    (ready),
      .rd_en_i    (rd_en[g]),
      .rd_addr_i  (rd_addr[g*ADDR_W +: ADDR_W]),
      .mem_word_i (rd_word[g]),
      .wr_en_i    (wr_qual),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_data_o  (rd_data[g*DATA_W +: DATA_W]),
      .rd_valid_o (rd_valid[g]),
      .oor_o      (rd_oor[g])
    );
  end

endmodule

// File: tb/tb_attn_mem_bank.sv
// -----------------------------------------------------------------------------
// tb_attn_mem_bank
// Directed bench for attn_mem_bank with DATA_W=32, ADDR_W=5, DEPTH=16,
// NUM_RD=2. Two instances share all inputs: u_dut0 reads old data on a
// same-address read/write, u_dut1 forwards the write data.
// Build with ATTN_MEM_OREG_EN defined to exercise the two-cycle read path.
// -----------------------------------------------------------------------------
module tb_attn_mem_bank;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DP = 16;
  localparam int NR = 2;
`ifdef ATTN_MEM_OREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;

  logic [NR*DW-1:0] rd_data0, rd_data1;
  logic [NR-1:0]    rd_valid0, rd_valid1;
  logic             init_done0, init_done1;
  logic             addr_err0, addr_err1;

  int total  = 0;
  int passed = 0;
  logic [DW-1:0] exp_mem [DP];

  always #5 clk = ~clk;

  attn_mem_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .NUM_RD(NR), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .init_done(init_done0), .addr_err(addr_err0)
  );

  attn_mem_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .NUM_RD(NR), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .init_done(init_done1), .addr_err(addr_err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
  endtask

  // Called on a falling edge; returns on the falling edge after the write.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < DP) exp_mem[a] = d;
  endtask

  // Issue one read cycle, check the response L cycles later on both
  // instances, then check the valid pulse ends and the data holds.
  task automatic rd2(input string tag, input logic [1:0] en,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    rd_en   = en;
    rd_addr = {a1, a0};
    @(negedge clk);
    rd_en = '0;
    repeat (L - 1) @(negedge clk);
    chk({tag, "_vld0"}, {30'b0, rd_valid0}, {30'b0, en});
    chk({tag, "_vld1"}, {30'b0, rd_valid1}, {30'b0, en});
    if (en[0]) begin
      chk({tag, "_d0c0"}, rd_data0[31:0], e0);
      chk({tag, "_d1c0"}, rd_data1[31:0], e0);
    end
    if (en[1]) begin
      chk({tag, "_d0c1"}, rd_data0[63:32], e1);
      chk({tag, "_d1c1"}, rd_data1[63:32], e1);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, {30'b0, rd_valid0}, 32'd0);
    if (en[0]) chk({tag, "_hold"}, rd_data0[31:0], e0);
  endtask

  // Count falling edges until init_done rises, bounded.
  task automatic wait_init(output int n, output logic quiet);
    n     = 0;
    quiet = 1'b1;
    while (!init_done0 && n < 100) begin
      @(negedge clk);
      n++;
      if (rd_valid0 != '0 || rd_valid1 != '0 || addr_err0 || addr_err1) quiet = 1'b0;
    end
  endtask

  initial begin
    int   n;
    logic quiet;

    for (int i = 0; i < DP; i++) exp_mem[i] = '0;
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_init_done", {31'b0, init_done0}, 32'd0);
    chk("rst_valid", {30'b0, rd_valid0}, 32'd0);
    chk("rst_data", rd_data0[31:0], 32'd0);
    chk("rst_err", {31'b0, addr_err0}, 32'd0);

    // Release reset while hammering the bank; everything must be ignored.
    rst_n   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd2;
    wr_data = 32'h5555_5555;
    rd_en   = 2'b11;
    rd_addr = {5'd20, 5'd20};
    wait_init(n, quiet);
    idle();
    chk("init_cycles", n, 32'd16);
    chk("init_quiet", {31'b0, quiet}, 32'd1);
    chk("init_done1", {31'b0, init_done1}, 32'd1);

    // Every word reads back zero
    for (int i = 0; i < DP; i++) rd2("sweep", 2'b11, AW'(i), AW'(DP - 1 - i), 32'd0, 32'd0);

    // Same address on both channels
    do_write(5'd3, 32'hDEAD_BEEF);
    rd2("dual", 2'b11, 5'd3, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Read during write to the same address
    do_write(5'd5, 32'h1111_1111);
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'h2222_2222;
    rd_en   = 2'b01;
    rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    idle();
    exp_mem[5] = 32'h2222_2222;
    repeat (L - 1) @(negedge clk);
    chk("rdw_vld0", {30'b0, rd_valid0}, 32'd1);
    chk("rdw_old", rd_data0[31:0], 32'h1111_1111);
    chk("rdw_vld1", {30'b0, rd_valid1}, 32'd1);
    chk("rdw_bypass", rd_data1[31:0], 32'h2222_2222);
    @(negedge clk);
    rd2("rdw_after", 2'b01, 5'd5, 5'd0, 32'h2222_2222, 32'd0);

    // Out-of-range write and read
    chk("err_before", {31'b0, addr_err0}, 32'd0);
    do_write(5'd20, 32'hAAAA_AAAA);
    chk("err_wr0", {31'b0, addr_err0}, 32'd1);
    chk("err_wr1", {31'b0, addr_err1}, 32'd1);
    rd2("oor_rd", 2'b11, 5'd20, 5'd20, 32'd0, 32'd0);
    for (int i = 0; i < DP; i++)
      rd2("intact", 2'b11, AW'(i), AW'(DP - 1 - i), exp_mem[i], exp_mem[DP - 1 - i]);
    chk("err_sticky", {31'b0, addr_err0}, 32'd1);

    // Reset between request and response
    rd_en   = 2'b11;
    rd_addr = {5'd3, 5'd3};
    #2 rst_n = 1'b0;
    @(negedge clk);
    idle();
    chk("abort_valid0", {30'b0, rd_valid0}, 32'd0);
    chk("abort_valid1", {30'b0, rd_valid1}, 32'd0);
    chk("abort_data", rd_data0[31:0], 32'd0);
    chk("abort_init", {31'b0, init_done0}, 32'd0);
    chk("abort_err", {31'b0, addr_err0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n, quiet);
    chk("resweep_cycles", n, 32'd16);
    chk("resweep_quiet", {31'b0, quiet}, 32'd1);
    for (int i = 0; i < DP; i++) exp_mem[i] = '0;
    rd2("resweep", 2'b11, 5'd3, 5'd5, 32'd0, 32'd0);
    chk("err_clear", {31'b0, addr_err0}, 32'd0);

    // Out-of-range read alone raises the flag
    rd2("oor_ch1", 2'b10, 5'd0, 5'd31, 32'd0, 32'd0);
    chk("err_rd", {31'b0, addr_err0}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
